spu_fx1_addsub_pipe: RTL
========================

Name: spu_fx1_addsub_pipe

Overview:
Parametrised, pipelined add/subtract datapath for the FX1 (simple fixed-point) unit of the SPU. It generalises the halfword add-immediate operation to halfword and word element modes, register or immediate second operand, and add or subtract-from. Results retire a fixed LAT cycles after issue, with stall and flush support from the issue/commit logic. It sits between the register-file read stage and the FX1 result bus.

Parameters:
DATA_W, 128, quadword width in bits; must be a multiple of 32.
IMM_W, 10, width of the immediate field (I10 format).
RT_W, 7, width of the target-register tag carried alongside the data.
LAT, 2, pipeline latency in cycles; legal range 1..4.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  issue strobe; an operation is accepted on any clk edge with in_valid=1 and stall=0
in_op  in  4  operation select (see Behaviour)
in_ra  in  DATA_W  operand RA, bit 0 = MSB, big-endian slot order [0:DATA_W-1]
in_rb  in  DATA_W  operand RB; ignored by immediate ops
in_imm  in  IMM_W  immediate, two's complement
in_rt  in  RT_W  target-register tag
stall  in  1  freezes every pipeline stage, including outputs
flush  in  1  kills every in-flight and same-cycle-issued operation
out_valid  out  1  result valid
out_result  out  DATA_W  result quadword
out_rt  out  RT_W  tag of the retiring operation
out_illegal  out  1  retiring operation had an unsupported opcode

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high. While rst=1 at a clk edge, every stage valid, out_valid, out_result, out_rt and out_illegal go to 0. Reset overrides stall and flush. Operations in flight when rst asserts are discarded and never retire.
- Opcodes (in_op). Halfword ops use 16-bit slots; word ops use 32-bit slots.
  - 0 AH: ra+rb, halfword.
  - 1 AHI: ra+ext16(imm).
  - 2 A: ra+rb, word.
  - 3 AI: ra+ext32(imm).
  - 4 SFH: rb-ra, halfword.
  - 5 SFHI: ext16(imm)-ra.
  - 6 SF: rb-ra, word.
  - 7 SFI: ext32(imm)-ra.
  - 8..15: illegal.
- Immediate handling: ext16/ext32 sign-extend imm from bit 0 to 16 or 32 bits. The extended value is replicated into every slot.
- Arithmetic: modulo 2^slot width, no saturation, no flags. Carries never propagate across slot boundaries. In halfword mode the carry out of bit 16k is cut.
- Slot count: DATA_W/16 in halfword mode, DATA_W/32 in word mode.
- Illegal opcode: the operation still flows through the pipeline and retires with out_illegal=1, out_result=0 and out_rt=in_rt.
- Pipeline timing:
  - Stage 1 registers the computed result, rt and illegal flag. Stages 2..LAT are pure delay registers.
  - An operation accepted at edge N with no stall retires with out_valid=1 during the cycle after edge N+LAT-1. Example: LAT=2, issue in cycle 0, visible in cycle 2.
  - Throughput is one operation per cycle; back-to-back issue is legal.
- Stall:
  - While stall=1, all stage registers and outputs hold their values and in_valid is not accepted.
  - A held out_valid=1 stays asserted for every stalled cycle. Downstream consumes a result only on a cycle with stall=0.
- Flush:
  - On an edge with flush=1, all stage valids and out_valid clear to 0, and any in_valid on that edge is dropped.
  - flush has priority over stall. Data registers need not clear.
  - Issue is accepted again from the next edge.
- Simultaneous stall=1 and flush=1: flush wins.
- Outputs when out_valid=0: out_result, out_rt and out_illegal are don't-care, except after reset, where they are 0.

Decomposition:
- Shared package spu_fx1_pkg:
  - opcode localparams (OP_AH..OP_SFI)
  - HW_SLOT=16 and WD_SLOT=32
  - shared function sext_imm(imm, width)
- Natural sub-module: spu_simd_addsub, the combinational slot-segmented adder.
  - Inputs: a, b, sub, hw_mode.
  - Generate loop over 16-bit slices, with the carry chain gated at each slice boundary when hw_mode=1.
  - Pipeline and control live in the top module.

Test Plan:
1. LAT=2, AHI, ra=0x0001 in every halfword, imm=10'h3FF -> cycle 2: out_result=0 and out_valid=1 for exactly one cycle; out_rt echoes the issued tag.
2. Slot isolation: ra=0x0000FFFF repeated, rb=0x00000001 repeated. AH -> 0x00000000 per word; A -> 0x00010000 per word. AI ra=0x7FFFFFFF, imm=1 -> 0x80000000 (wrap, no saturation).
3. Subtract-from: SFH ra=0x0007, rb=0x0005 -> 0xFFFE per halfword. SFI ra=3, imm=10'h200 (-512) -> 0xFFFFFDFD per word.
4. Back-to-back: 8 consecutive AI ops with imm=0..7 and rt=0..7 -> 8 consecutive out_valid cycles in issue order. Insert 2 stall cycles mid-stream -> outputs hold, no loss or duplication.
5. Flush with 2 ops in flight plus one issued on the flush edge -> none retire. The next op issued after the flush retires normally. flush and stall asserted together -> pipeline empties.
6. in_op=12 -> out_illegal=1, out_result=0. Assert rst with ops in flight -> next cycle all outputs 0 and nothing retires afterwards. Repeat tests 1–4 with LAT=1 and LAT=4.

Source files
------------

// File: rtl/spu_fx1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spu_fx1_pkg
// Description : Shared definitions for the SPU FX1 add/subtract datapath:
//               opcode encodings, SIMD slot widths and the immediate
//               sign-extension helper.
// Revision    : 1.0 - initial release
// ============================================================================
package spu_fx1_pkg;

    // Opcode encoding: bit 0 = immediate second operand, bit 1 = word slots,
    // bit 2 = subtract-from, bit 3 set = illegal.
    localparam logic [3:0] OP_AH   = 4'd0;
    localparam logic [3:0] OP_AHI  = 4'd1;
    localparam logic [3:0] OP_A    = 4'd2;
    localparam logic [3:0] OP_AI   = 4'd3;
    localparam logic [3:0] OP_SFH  = 4'd4;
    localparam logic [3:0] OP_SFHI = 4'd5;
    localparam logic [3:0] OP_SF   = 4'd6;
    localparam logic [3:0] OP_SFI  = 4'd7;

    localparam int HW_SLOT = 16;
    localparam int WD_SLOT = 32;

    // Sign-extend the low imm_w bits of imm to 'width' bits (width <= 32).
    // Bits above 'width' in the return value are zero.
    function automatic logic [31:0] sext_imm(input logic [31:0] imm,
                                             input int          imm_w,
                                             input int          width);
        logic [31:0] t;
        t = imm << (32 - imm_w);
        t = $signed(t) >>> (32 - imm_w);
        if (width < 32) begin
            t = t & ((32'd1 << width) - 32'd1);
        end
        return t;
    endfunction

endpackage : spu_fx1_pkg
`default_nettype wire

// File: rtl/spu_simd_addsub.sv
`default_nettype none
// ============================================================================
// Module      : spu_simd_addsub
// Description : Combinational slot-segmented adder. Computes a + b or
//               a - b (as a + ~b + 1) independently in every 16-bit slot
//               (hw_mode_i = 1) or every 32-bit slot (hw_mode_i = 0).
// Ports       : a_i, b_i   - operands, DATA_W bits
//               sub_i      - 1 = a_i - b_i, 0 = a_i + b_i
//               hw_mode_i  - 1 = 16-bit slots, 0 = 32-bit slots
//               sum_o      - slot-wise result
// Revision    : 1.0 - initial release
// ============================================================================
module spu_simd_addsub #(
    parameter int DATA_W = 128
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    input  logic              hw_mode_i,
    output logic [DATA_W-1:0] sum_o
);

    localparam int NSL = DATA_W / 16;

    logic [DATA_W-1:0] b_eff_w;
    // Carry out of each even (word-low) slice; the carry out of odd slices
    // always leaves a word and is discarded.
    logic [NSL/2-1:0]  carry_w;

    assign b_eff_w = sub_i ? ~b_i : b_i;

    // Slice 0 holds the least significant 16 bits. A word is the pair of
    // slices {2j+1, 2j}; the carry between them is cut in halfword mode.
    for (genvar k = 0; k < NSL; k++) begin : g_slice
        if ((k % 2) == 0) begin : g_word_lo
            logic [16:0] s_w;
            assign s_w = {1'b0, a_i[16*k +: 16]} + {1'b0, b_eff_w[16*k +: 16]}
                       + {16'd0, sub_i};
            assign sum_o[16*k +: 16] = s_w[15:0];
            assign carry_w[k/2]      = s_w[16];
        end else begin : g_word_hi
            logic cin_w;
            assign cin_w = hw_mode_i ? sub_i : carry_w[k/2];
            assign sum_o[16*k +: 16] = a_i[16*k +: 16] + b_eff_w[16*k +: 16]
                                     + {15'd0, cin_w};
        end
    end

endmodule : spu_simd_addsub
`default_nettype wire

// File: rtl/spu_fx1_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : spu_fx1_addsub_pipe
// Description : Pipelined SIMD add/subtract-from datapath for the SPU FX1
//               unit. Halfword/word slots, register or I10 immediate second
//               operand. Results retire LAT cycles after issue (LAT 1..4),
//               with stall (freeze all stages) and flush (kill all valids).
// Ports       : clk, rst           - clock, synchronous active-high reset
//               in_valid, in_op    - issue strobe and opcode
//               in_ra, in_rb       - operands (slot 0 in the top bits)
//               in_imm, in_rt      - immediate and target tag
//               stall, flush       - pipeline control
//               out_valid, out_result, out_rt, out_illegal - retire port
// Revision    : 1.0 - initial release
// ============================================================================
module spu_fx1_addsub_pipe
    import spu_fx1_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int IMM_W  = 10,
    parameter int RT_W   = 7,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_ra,
    input  logic [DATA_W-1:0] in_rb,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [RT_W-1:0]   in_rt,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [RT_W-1:0]   out_rt,
    output logic              out_illegal
);

    localparam int NHW = DATA_W / HW_SLOT;
    localparam int NWD = DATA_W / WD_SLOT;

    // ---------------- decode and operand selection ----------------
    logic                is_imm_w, is_word_w, is_sub_w, illegal_w;
    logic [HW_SLOT-1:0]  imm16_w;
    logic [WD_SLOT-1:0]  imm32_w;
    logic [DATA_W-1:0]   opb_w, add_a_w, add_b_w, sum_w, res_d;

    assign is_imm_w  = in_op[0];
    assign is_word_w = in_op[1];
    assign is_sub_w  = in_op[2];
    assign illegal_w = in_op[3];

    assign imm16_w = HW_SLOT'(sext_imm(32'(in_imm), IMM_W, HW_SLOT));
    assign imm32_w = sext_imm(32'(in_imm), IMM_W, WD_SLOT);

    assign opb_w = !is_imm_w ? in_rb
                 : (is_word_w ? {NWD{imm32_w}} : {NHW{imm16_w}});

    // Subtract-from computes opb - ra, so the operands swap for sub ops.
    assign add_a_w = is_sub_w ? opb_w : in_ra;
    assign add_b_w = is_sub_w ? in_ra : opb_w;

    spu_simd_addsub #(
        .DATA_W (DATA_W)
    ) u_addsub (
        .a_i       (add_a_w),
        .b_i       (add_b_w),
        .sub_i     (is_sub_w),
        .hw_mode_i (~is_word_w),
        .sum_o     (sum_w)
    );

    assign res_d = illegal_w ? '0 : sum_w;

    // ---------------- pipeline stages ----------------
    // Stage 0 holds the computed result; stages 1..LAT-1 are pure delay.
    logic              vld_q [LAT];
    logic [DATA_W-1:0] res_q [LAT];
    logic [RT_W-1:0]   rt_q  [LAT];
    logic              ill_q [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                vld_q[s] <= 1'b0;
                res_q[s] <= '0;
                rt_q[s]  <= '0;
                ill_q[s] <= 1'b0;
            end
        end else if (flush) begin
            // Only the valids need clearing; stale data is never exposed
            // as valid.
            for (int s = 0; s < LAT; s++) begin
                vld_q[s] <= 1'b0;
            end
        end else if (!stall) begin
            vld_q[0] <= in_valid;
            // Data captured only on issue so the retire port stays at zero
            // after reset until a real operation arrives.
            if (in_valid) begin
                res_q[0] <= res_d;
                rt_q[0]  <= in_rt;
                ill_q[0] <= illegal_w;
            end
            for (int s = 1; s < LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                res_q[s] <= res_q[s-1];
                rt_q[s]  <= rt_q[s-1];
                ill_q[s] <= ill_q[s-1];
            end
        end
    end

    assign out_valid   = vld_q[LAT-1];
    assign out_result  = res_q[LAT-1];
    assign out_rt      = rt_q[LAT-1];
    assign out_illegal = ill_q[LAT-1];

endmodule : spu_fx1_addsub_pipe
`default_nettype wire
